regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-ported integer register file with an integrated busy-bit scoreboard, the next generation of the two-write/two-read `regfile` used by the dual-issue RISC-V datapath. It provides `NR` asynchronous read ports and `NW` synchronous write ports over `NREGS` registers of `XLEN` bits. Register x0 is hardwired to zero. A per-register busy bit lets issue logic detect pending writebacks. It sits between decode/issue (reads, allocation) and writeback (writes, busy release).

## Interface
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of registers (power of two, ≥ 2); `AW = $clog2(NREGS)`
- `NR`, 2, read port count (≥ 1)
- `NW`, 2, write port count (≥ 1); higher index = higher priority
- `clk`  in  1  clock, rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `we`  in  NW  per-port write enable
- `wa`  in  NW*AW  write addresses; port i in bits [i*AW +: AW]
- `wd`  in  NW*XLEN  write data; port i in bits [i*XLEN +: XLEN]
- `ra`  in  NR*AW  read addresses, packed as `wa`
- `rd`  out  NR*XLEN  read data, packed as `wd`
- `alloc`  in  NW  per-port busy-set request (destination allocated at issue)
- `alloc_a`  in  NW*AW  allocation addresses
- `flush`  in  1  synchronous clear of all busy bits
- `rbusy`  out  NR  busy bit of the register addressed by each read port
- `busy`  out  NREGS  full busy vector

## Operation
- Storage: registers 1..NREGS-1 of XLEN bits; x0 not stored, always reads 0, never busy.
- Write: on rising `clk`, for each port i with `we[i]=1` and `wa` ≠ 0, reg[wa_i] ← wd_i.
- Write conflict (two enabled ports, same address): highest-index port's data is stored; lower ports' data for that address discarded.
- Writes to x0 ignored, no side effects.
- Read: `rd_i` = reg[ra_i] combinationally; x0 → 0.
- Scoreboard, per rising edge, per register r ≠ 0:
  - clear if any enabled write port targets r;
  - set if any `alloc[i]` targets r;
  - set beats clear in the same cycle (new producer supersedes retiring one);
  - `flush=1` clears all busy bits and overrides same-cycle sets.
- `rbusy[i]` = busy[ra_i] (0 for x0); `busy` = stored vector, bit 0 constant 0.

## Timing
- Reset (`reset_n`=0, asynchronous): all registers 0, all busy bits 0; hence `rd`=0, `rbusy`=0, `busy`=0 while asserted and after release. Reset mid-write drops the write.
- Deassertion: synchronous release assumed upstream; first write honoured on the first rising edge with `reset_n`=1.
- Read latency: 0 cycles (combinational address-to-data).
- Write latency: data visible on `rd` after the rising edge capturing it.
- Busy latency: set/clear visible after the capturing edge.
- Same-cycle read of a register being written: see Configuration.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write-to-read forwarding. If a read address matches an enabled write port (non-zero), `rd_i` returns that port's `wd` (highest-index match), and `rbusy_i` reports 0 unless the same register is also being allocated this cycle.
- Undefined: `rd_i` and `rbusy_i` reflect stored state only; a same-cycle write is seen on the following cycle.

## Test plan
- Reset then `we`=2'b01, wa0=1, wd0=0x42424242; next cycle `we`=2'b10, wa1=2, wd1=0xdeadbeef; ra0=1, ra1=2 → rd0=0x42424242 after first edge, rd1=0xdeadbeef after second.
- Conflict: both ports write x5, wd0=0x11111111, wd1=0x22222222 → read x5 = 0x22222222.
- x0: write 0xffffffff to x0 and alloc x0 → rd=0, `busy[0]`=0, `rbusy`=0.
- Scoreboard: alloc x7 → `busy[7]`=1 next cycle; same cycle write x7 and alloc x7 → stays 1; write x7 only → 0; alloc x3,x4 then `flush` → `busy`=0.
- Bypass: write 0xcafef00d to x9 while ra0=9 → with `REGFILE_BYPASS_EN` rd0=0xcafef00d same cycle; without, old value until after edge.
- Async reset: pull `reset_n` low between edges after writes → all `rd`, `busy` 0 immediately, no clock required.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported integer register file (x0 hardwired to zero) with a busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy release to the read ports.
module regfile_mp #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NR    = 2,
    parameter  int NW    = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NW-1:0]     we,
    input  logic [NW*AW-1:0]  wa,
    input  logic [NW*XLEN-1:0] wd,
    input  logic [NR*AW-1:0]  ra,
    output logic [NR*XLEN-1:0] rd,
    input  logic [NW-1:0]     alloc,
    input  logic [NW*AW-1:0]  alloc_a,
    input  logic              flush,
    output logic [NR-1:0]     rbusy,
    output logic [NREGS-1:0]  busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] al_hit;

    // Per-register decode of write and allocation targets; x0 is never decoded.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
        wr_hit = '0;
        al_hit = '0;
        for (int r = 1; r < NREGS; r++) begin
            for (int i = 0; i < NW; i++) begin
                if (we[i] && wa[i*AW +: AW] == AW'(r))
                    wr_hit[r] = 1'b1;
                if (alloc[i] && alloc_a[i*AW +: AW] == AW'(r))
                    al_hit[r] = 1'b1;
            end
        end
    end

    // Set beats clear; flush beats everything.
    always_comb begin
        busy_d = flush ? '0 : ((busy_q & ~wr_hit) | al_hit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the array is reset explicitly because reads must return zero straight out of reset.
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                for (int i = 0; i < NW; i++) begin
                    // NOTE: non-blocking updates; when several ports hit r, the last (highest-index) assignment wins.
                    if (we[i] && wa[i*AW +: AW] == AW'(r))
                        regs[r] <= wd[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int p = 0; p < NR; p++) begin
            if (ra[p*AW +: AW] != '0) begin
                rd[p*XLEN +: XLEN] = regs[ra[p*AW +: AW]];
                rbusy[p]           = busy_q[ra[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int i = 0; i < NW; i++) begin
                    if (we[i] && wa[i*AW +: AW] == ra[p*AW +: AW]) begin
                        rd[p*XLEN +: XLEN] = wd[i*XLEN +: XLEN];
                        rbusy[p]           = al_hit[ra[p*AW +: AW]];
                    end
                end
`endif
            end
        end
    end

    assign busy = busy_q;

endmodule
